// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the ad_pulse frequency/duty meter.
package pulse_meter_pkg;

  // Default width of every counter and result port.
  localparam int unsigned CNT_W_DEF = 32;

  // Measurement controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_rise_det.sv
// Registered rising-edge detector for a pulse that is already in the clk domain.
// rise_o is high in the cycle where pulse_i is 1 and was 0 one cycle earlier.
module pulse_rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pulse_i,
  output logic rise_o
);

  logic pulse_q;

  // One-cycle delayed copy of the pulse, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_i;
    end
  end

  assign rise_o = pulse_i & ~pulse_q;

endmodule

// File: rtl/pulse_freq_meter.sv
// Equal-precision frequency/duty meter. The window opens on a rising edge of
// ad_pulse and closes on the first rising edge once GATE_CYCLES have elapsed,
// so the window always covers a whole number of signal periods.
module pulse_freq_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned GATE_CYCLES    = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             ad_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ad_pulse,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] sig_cnt,
  output logic [CNT_W-1:0] clk_cnt,
  output logic [CNT_W-1:0] high_cnt
);

  localparam logic [CNT_W-1:0] GATE_C  = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_run_q, clk_run_d;
  logic [CNT_W-1:0] sig_run_q, sig_run_d;
  logic [CNT_W-1:0] high_run_q, high_run_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] sig_cnt_q, sig_cnt_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             rise_s;
  logic [CNT_W-1:0] rise_ext_s;
  logic [CNT_W-1:0] pulse_ext_s;

  pulse_rise_det u_rise_det (
    .clk_i   (ad_clk),
    .rst_i   (rst),
    .pulse_i (ad_pulse),
    .rise_o  (rise_s)
  );

  assign rise_ext_s  = {{(CNT_W-1){1'b0}}, rise_s};
  assign pulse_ext_s = {{(CNT_W-1){1'b0}}, ad_pulse};

  // Next-state, window counters, idle watchdog and result latching.
  always_comb begin
    state_d    = state_q;
    clk_run_d  = clk_run_q;
    sig_run_d  = sig_run_q;
    high_run_d = high_run_q;
    idle_d     = idle_q;
    sig_cnt_d  = sig_cnt_q;
    clk_cnt_d  = clk_cnt_q;
    high_cnt_d = high_cnt_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        // A rise in the start cycle is deliberately not treated as E0.
        if (start) begin
          state_d = ARM;
          idle_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end

      ARM: begin
        if (rise_s) begin
          // E0: its own cycle counts as the first window cycle, pulse is high.
          state_d    = GATE;
          clk_run_d  = ONE_C;
          sig_run_d  = '0;
          high_run_d = ONE_C;
          idle_d     = '0;
        end else if (idle_q == TO_LAST) begin
          state_d    = DONE;
          sig_cnt_d  = '0;
          clk_cnt_d  = '0;
          high_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          idle_d = idle_q + ONE_C;
        end
      end

      GATE: begin
        if (rise_s && (clk_run_q >= GATE_C)) begin
          // Closing edge: its own cycle belongs to the next period, not counted.
          state_d    = DONE;
          sig_cnt_d  = sig_run_q + ONE_C;
          clk_cnt_d  = clk_run_q;
          high_cnt_d = high_run_q;
          timeout_d  = 1'b0;
        end else if (!rise_s && (idle_q == TO_LAST)) begin
          state_d    = DONE;
          sig_cnt_d  = '0;
          clk_cnt_d  = '0;
          high_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          clk_run_d  = clk_run_q + ONE_C;
          sig_run_d  = sig_run_q + rise_ext_s;
          high_run_d = high_run_q + pulse_ext_s;
          if (rise_s) begin
            idle_d = '0;
          end else begin
            idle_d = idle_q + ONE_C;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, counter and result registers with synchronous reset priority.
  always_ff @(posedge ad_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_run_q  <= '0;
      sig_run_q  <= '0;
      high_run_q <= '0;
      idle_q     <= '0;
      sig_cnt_q  <= '0;
      clk_cnt_q  <= '0;
      high_cnt_q <= '0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_run_q  <= clk_run_d;
      sig_run_q  <= sig_run_d;
      high_run_q <= high_run_d;
      idle_q     <= idle_d;
      sig_cnt_q  <= sig_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
      high_cnt_q <= high_cnt_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign sig_cnt  = sig_cnt_q;
  assign clk_cnt  = clk_cnt_q;
  assign high_cnt = high_cnt_q;

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Self-checking bench for pulse_freq_meter (GATE_CYCLES=20, TIMEOUT_CYCLES=50).
// Expected results are pushed to a scoreboard queue when a measurement is
// launched and popped when the meter raises done.
module tb_pulse_freq_meter;

  localparam int unsigned GATE = 20;
  localparam int unsigned TOUT = 50;
  localparam int          BUDGET = 300;

  typedef struct {
    logic        to;
    logic [31:0] sig;
    logic [31:0] clk;
    logic [31:0] high;
  } exp_t;

  logic        ad_clk = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        ad_pulse = 1'b0;
  logic        busy, done, timeout;
  logic [31:0] sig_cnt, clk_cnt, high_cnt;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Waveform description used by wave_val().
  int   w_mode  = 0;   // 0 constant level, 1 periodic
  logic w_level = 1'b0;
  int   w_p = 4, w_h = 2, w_nper = 0, w_lead = 0;
  bit   w_spike = 1'b0;

  pulse_freq_meter #(
    .CNT_W          (32),
    .GATE_CYCLES    (GATE),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .ad_clk   (ad_clk),
    .rst      (rst),
    .start    (start),
    .ad_pulse (ad_pulse),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .sig_cnt  (sig_cnt),
    .clk_cnt  (clk_cnt),
    .high_cnt (high_cnt)
  );

  always #5 ad_clk = ~ad_clk;

  // Pulse level at cycle t relative to the start cycle (t=0).
  function automatic logic wave_val(input int t);
    int u;
    if (w_mode == 0) return w_level;
    if (t < w_lead) return (w_spike && t == 0);
    u = t - w_lead;
    if (w_nper != 0 && u >= w_nper * w_p) return 1'b0;
    return ((u % w_p) < w_h);
  endfunction

  // Reference result for a periodic input: first edge with n*P >= GATE closes.
  function automatic exp_t exp_periodic(input int p, input int h);
    exp_t e;
    int n;
    n = (GATE + p - 1) / p;
    e.to = 1'b0; e.sig = n; e.clk = n * p; e.high = n * h;
    return e;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge ad_clk);
      start = 1'b0;
      ad_pulse = 1'b0;
    end
  endtask

  // Pulse start at t=0, drive the waveform, stop at done or after the budget.
  // Extra start pulses are driven at t=start_at and t=start_at+3 (0 = none).
  task automatic run_meas(input int start_at, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    @(negedge ad_clk);
    start = 1'b1;
    ad_pulse = wave_val(0);
    for (int t = 1; t <= BUDGET; t++) begin
      @(negedge ad_clk);
      if (done === 1'b1) begin
        got = 1'b1;
        cyc = t;
        break;
      end
      start = (start_at != 0) && (t == start_at || t == start_at + 3);
      ad_pulse = wave_val(t);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ad_pulse = 1'b0;
    repeat (3) @(negedge ad_clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
    n_checks++; if (sig_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_sig: got %0d want 0", sig_cnt); end
    n_checks++; if (clk_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_clk: got %0d want 0", clk_cnt); end
    n_checks++; if (high_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_high: got %0d want 0", high_cnt); end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_periodic();
    int tbl_p[4] = '{4, 7, 5, 3};
    int tbl_h[4] = '{2, 2, 3, 1};
    bit got; int cyc; exp_t e;
    for (int k = 0; k < 4; k++) begin
      w_mode = 1; w_p = tbl_p[k]; w_h = tbl_h[k]; w_nper = 0; w_lead = 0; w_spike = 1'b0;
      sb_q.push_back(exp_periodic(w_p, w_h));
      run_meas(0, got, cyc);
      e = sb_q.pop_front();
      n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL periodic_done P=%0d: no done in %0d cycles", w_p, BUDGET); end
      n_checks++; if (timeout !== e.to) begin n_errors++; $display("FAIL periodic_to P=%0d: got %0b want %0b", w_p, timeout, e.to); end
      n_checks++; if (sig_cnt !== e.sig) begin n_errors++; $display("FAIL periodic_sig P=%0d: got %0d want %0d", w_p, sig_cnt, e.sig); end
      n_checks++; if (clk_cnt !== e.clk) begin n_errors++; $display("FAIL periodic_clk P=%0d: got %0d want %0d", w_p, clk_cnt, e.clk); end
      n_checks++; if (high_cnt !== e.high) begin n_errors++; $display("FAIL periodic_high P=%0d: got %0d want %0d", w_p, high_cnt, e.high); end
      idle_cycles(3);
    end
  endtask

  task automatic test_timeout_dc();
    bit got; int cyc; exp_t e;
    for (int lvl = 0; lvl < 2; lvl++) begin
      w_mode = 0; w_level = lvl[0];
      sb_q.push_back('{to: 1'b1, sig: 32'd0, clk: 32'd0, high: 32'd0});
      run_meas(0, got, cyc);
      e = sb_q.pop_front();
      n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL dc%0d_done: no done in %0d cycles", lvl, BUDGET); end
      n_checks++; if (cyc != TOUT + 1) begin n_errors++; $display("FAIL dc%0d_latency: got %0d want %0d", lvl, cyc, TOUT + 1); end
      n_checks++; if (timeout !== e.to) begin n_errors++; $display("FAIL dc%0d_to: got %0b want %0b", lvl, timeout, e.to); end
      n_checks++; if ({sig_cnt, clk_cnt, high_cnt} !== {e.sig, e.clk, e.high}) begin
        n_errors++; $display("FAIL dc%0d_counts: got %0d/%0d/%0d want 0/0/0", lvl, sig_cnt, clk_cnt, high_cnt);
      end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL dc%0d_busy_at_done: got %0b want 1", lvl, busy); end
      @(negedge ad_clk);
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL dc%0d_busy_after: got %0b want 0", lvl, busy); end
      idle_cycles(3);
    end
  endtask

  task automatic test_timeout_in_gate();
    bit got; int cyc; exp_t e;
    // A good measurement first so the timeout must overwrite nonzero results.
    w_mode = 1; w_p = 5; w_h = 3; w_nper = 0; w_lead = 0; w_spike = 1'b0;
    sb_q.push_back(exp_periodic(5, 3));
    run_meas(0, got, cyc);
    e = sb_q.pop_front();
    n_checks++; if (got !== 1'b1 || clk_cnt !== e.clk || high_cnt !== e.high || sig_cnt !== e.sig) begin
      n_errors++; $display("FAIL pre_meas: got done=%0b %0d/%0d/%0d want 1 %0d/%0d/%0d", got, sig_cnt, clk_cnt, high_cnt, e.sig, e.clk, e.high);
    end
    idle_cycles(3);
    w_p = 4; w_h = 2; w_nper = 3;
    sb_q.push_back('{to: 1'b1, sig: 32'd0, clk: 32'd0, high: 32'd0});
    run_meas(0, got, cyc);
    e = sb_q.pop_front();
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL gate_to_done: no done in %0d cycles", BUDGET); end
    n_checks++; if (timeout !== e.to) begin n_errors++; $display("FAIL gate_to_flag: got %0b want %0b", timeout, e.to); end
    n_checks++; if (sig_cnt !== e.sig) begin n_errors++; $display("FAIL gate_to_sig: got %0d want %0d", sig_cnt, e.sig); end
    n_checks++; if (clk_cnt !== e.clk) begin n_errors++; $display("FAIL gate_to_clk: got %0d want %0d", clk_cnt, e.clk); end
    n_checks++; if (high_cnt !== e.high) begin n_errors++; $display("FAIL gate_to_high: got %0d want %0d", high_cnt, e.high); end
    // Last rise at t=8: watchdog expires TOUT cycles later, done one edge after.
    n_checks++; if (cyc != 8 + TOUT + 1) begin n_errors++; $display("FAIL gate_to_latency: got %0d want %0d", cyc, 8 + TOUT + 1); end
    idle_cycles(3);
  endtask

  task automatic test_start_edge_and_restart();
    bit got; int cyc; int extra; exp_t e;
    // Rise in the start cycle, silence until t=10, then P=4 H=2 from t=10.
    w_mode = 1; w_p = 4; w_h = 2; w_nper = 0; w_lead = 10; w_spike = 1'b1;
    sb_q.push_back('{to: 1'b0, sig: 32'd5, clk: 32'd20, high: 32'd10});
    run_meas(15, got, cyc);
    e = sb_q.pop_front();
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL edge_done: no done in %0d cycles", BUDGET); end
    n_checks++; if (timeout !== e.to) begin n_errors++; $display("FAIL edge_to: got %0b want %0b", timeout, e.to); end
    n_checks++; if (sig_cnt !== e.sig) begin n_errors++; $display("FAIL edge_sig: got %0d want %0d", sig_cnt, e.sig); end
    n_checks++; if (clk_cnt !== e.clk) begin n_errors++; $display("FAIL edge_clk: got %0d want %0d", clk_cnt, e.clk); end
    n_checks++; if (high_cnt !== e.high) begin n_errors++; $display("FAIL edge_high: got %0d want %0d", high_cnt, e.high); end
    n_checks++; if (cyc != 10 + 20 + 1) begin n_errors++; $display("FAIL edge_latency: got %0d want %0d", cyc, 31); end
    extra = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge ad_clk);
      start = 1'b0;
      ad_pulse = wave_val(cyc + 1 + t);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) begin n_errors++; $display("FAIL single_done: got %0d busy/done cycles after done want 0", extra); end
    idle_cycles(3);
  endtask

  task automatic test_reset_mid_gate();
    bit got; int cyc; int stray; exp_t e;
    w_mode = 1; w_p = 4; w_h = 2; w_nper = 0; w_lead = 0; w_spike = 1'b0;
    @(negedge ad_clk);
    start = 1'b1; ad_pulse = wave_val(0);
    for (int t = 1; t <= 12; t++) begin
      @(negedge ad_clk);
      start = 1'b0; ad_pulse = wave_val(t);
    end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy: got %0b want 1", busy); end
    rst = 1'b1;
    @(negedge ad_clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst_flags: got busy=%0b done=%0b to=%0b want 0", busy, done, timeout);
    end
    n_checks++; if ({sig_cnt, clk_cnt, high_cnt} !== 96'd0) begin
      n_errors++; $display("FAIL mid_rst_counts: got %0d/%0d/%0d want 0/0/0", sig_cnt, clk_cnt, high_cnt);
    end
    rst = 1'b0;
    stray = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge ad_clk);
      ad_pulse = wave_val(14 + t);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    n_checks++; if (stray != 0) begin n_errors++; $display("FAIL mid_rst_stray: got %0d active cycles want 0", stray); end
    idle_cycles(2);
    w_p = 7; w_h = 2;
    sb_q.push_back(exp_periodic(7, 2));
    run_meas(0, got, cyc);
    e = sb_q.pop_front();
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL post_rst_done: no done in %0d cycles", BUDGET); end
    n_checks++; if ({timeout, sig_cnt, clk_cnt, high_cnt} !== {e.to, e.sig, e.clk, e.high}) begin
      n_errors++; $display("FAIL post_rst_meas: got %0b %0d/%0d/%0d want %0b %0d/%0d/%0d",
                           timeout, sig_cnt, clk_cnt, high_cnt, e.to, e.sig, e.clk, e.high);
    end
    idle_cycles(3);
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_timeout_dc();
    test_timeout_in_gate();
    test_start_edge_and_restart();
    test_reset_mid_gate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
